// File: rtl/pagerank_stream_gen_if.sv
// pagerank_stream_gen_if
//   Bundles the pagerank serial-stream bus between the stream generator
//   and its consumer (the accumulate/damp block).
//   master : generator side. It takes start and the iteration inputs, and it
//            drives the stream words, the framing pulses, src_index, busy and
//            iterations_sent.
//   slave  : consumer / stimulus side (the mirror image of master).
interface pagerank_stream_gen_if #(
   parameter int NODES_IN_GRAPH = 32
);
   logic                                          start;
   logic [NODES_IN_GRAPH-1:0][63:0]               pagerank_in;
   logic [NODES_IN_GRAPH-1:0][63:0]               inv_outdeg;
   logic [NODES_IN_GRAPH-1:0][NODES_IN_GRAPH-1:0] adjacency;   // [src][dst]
   logic [NODES_IN_GRAPH-1:0][63:0]               pagerank_serial_stream;
   logic                                          stream_start;
   logic                                          stream_valid;
   logic                                          stream_done;
   logic [31:0]                                   src_index;
   logic                                          busy;
   logic [31:0]                                   iterations_sent;

   modport master (
      input  start, pagerank_in, inv_outdeg, adjacency,
      output pagerank_serial_stream, stream_start, stream_valid, stream_done,
             src_index, busy, iterations_sent
   );

   modport slave (
      output start, pagerank_in, inv_outdeg, adjacency,
      input  pagerank_serial_stream, stream_start, stream_valid, stream_done,
             src_index, busy, iterations_sent
   );
endinterface

// File: rtl/pagerank_stream_gen.sv
// pagerank_stream_gen
//   Transmit side of the pagerank serial stream. On start (in IDLE) it
//   snapshots the pagerank vector, the reciprocal out-degrees and the
//   adjacency matrix. It then emits a stream_start pulse, one beat per
//   source node, and a stream_done pulse. Each beat carries
//   pagerank[s]*inv_outdeg[s] to every destination d that has
//   adjacency[s][d] set.
//   Ports:
//     clock : rising-edge system clock
//     reset : synchronous, active-high
//     bus   : pagerank_stream_gen_if.master (start, inputs, stream outputs)
//   All outputs come straight from registers. There is no input-to-output
//   combinational path.
module pagerank_stream_gen #(
   parameter int NODES_IN_GRAPH = 32,
   parameter int FRAC_BITS      = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   pagerank_stream_gen_if.master     bus
);
   localparam int IDX_W = $clog2(NODES_IN_GRAPH);

   typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

   state_t                                        r_state;
   logic [NODES_IN_GRAPH-1:0][63:0]               r_pr_snap;
   logic [NODES_IN_GRAPH-1:0][63:0]               r_inv_snap;
   logic [NODES_IN_GRAPH-1:0][NODES_IN_GRAPH-1:0] r_adj_snap;
   logic [NODES_IN_GRAPH-1:0][63:0]               r_stream;
   logic [IDX_W-1:0]                              r_src;
   logic                                          r_stream_start;
   logic                                          r_valid;
   logic                                          r_done;
   logic                                          r_busy;
   logic [31:0]                                   r_iter;

   logic [IDX_W-1:0]                              w_sel;
   logic [127:0]                                  w_prod;
   logic [127:0]                                  w_shifted;
   logic [63:0]                                   w_contrib;
   logic [NODES_IN_GRAPH-1:0][63:0]               w_beat;

   // The beat is registered directly from the snapshot. The source that is
   // evaluated is the one due on the *next* beat: source 0 while in PRIME,
   // and src_index+1 while streaming.
   always_comb begin
      w_sel     = (r_state == PRIME) ? '0 : r_src + IDX_W'(1);
      w_prod    = {64'd0, r_pr_snap[w_sel]} * {64'd0, r_inv_snap[w_sel]};
      w_shifted = w_prod >> FRAC_BITS;
      // Any significance above the 64-bit result window saturates.
      w_contrib = (w_shifted[127:64] != '0) ? '1 : w_shifted[63:0];
      w_beat    = '0;
      for (int unsigned d = 0; d < NODES_IN_GRAPH; d++) begin
         w_beat[d] = r_adj_snap[w_sel][d] ? w_contrib : '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= IDLE;
         r_pr_snap      <= '0;
         r_inv_snap     <= '0;
         r_adj_snap     <= '0;
         r_stream       <= '0;
         r_src          <= '0;
         r_stream_start <= 1'b0;
         r_valid        <= 1'b0;
         r_done         <= 1'b0;
         r_busy         <= 1'b0;
         r_iter         <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_pr_snap      <= bus.pagerank_in;
                  r_inv_snap     <= bus.inv_outdeg;
                  r_adj_snap     <= bus.adjacency;
                  r_src          <= '0;
                  r_stream_start <= 1'b1;
                  r_busy         <= 1'b1;
                  r_state        <= PRIME;
               end
            end
            PRIME: begin
               r_stream_start <= 1'b0;
               r_valid        <= 1'b1;
               r_stream       <= w_beat;
               r_src          <= '0;
               r_state        <= STREAM;
            end
            STREAM: begin
               if (r_src == IDX_W'(NODES_IN_GRAPH - 1)) begin
                  r_valid  <= 1'b0;
                  r_stream <= '0;
                  r_done   <= 1'b1;
                  r_iter   <= r_iter + 32'd1;
                  r_state  <= DONE;
               end else begin
                  r_src    <= w_sel;
                  r_stream <= w_beat;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.pagerank_serial_stream = r_stream;
   assign bus.stream_start           = r_stream_start;
   assign bus.stream_valid           = r_valid;
   assign bus.stream_done            = r_done;
   assign bus.src_index              = 32'(r_src);
   assign bus.busy                   = r_busy;
   assign bus.iterations_sent        = r_iter;
endmodule
